// File: rtl/w_stage_grf.sv
// w_stage_grf: MIPS write-back stage with M/W register, sub-word load extension and a bypassed 32x32 register file
module w_stage_grf #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int REG_NUM = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_M,
  input  logic [31:0] pc_M,
  input  logic [31:0] alu_M,
  input  logic [31:0] dm_M,
  output logic [5:0]  op_W,
  output logic [5:0]  fun_W,
  input  logic        GRFwe,
  input  logic [1:0]  WAop,
  input  logic [1:0]  WDop,
  input  logic [4:0]  ra1_D,
  input  logic [4:0]  ra2_D,
  output logic [31:0] rd1_D,
  output logic [31:0] rd2_D,
  output logic [4:0]  wa_W,
  output logic [31:0] wd_W,
  output logic        we_W,
  output logic [31:0] pc_W
);
  logic [5:0]  op_q, fun_q;
  logic [4:0]  rt_q, rd_q, wa;
  logic [31:0] pc_q, alu_q, dm_q, ld;
  logic [31:0] rf_q [REG_NUM];
  logic [15:0] hw;
  logic [7:0]  by;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      op_q  <= '0;
      fun_q <= '0;
      rt_q  <= '0;
      rd_q  <= '0;
      pc_q  <= RESET_PC;
      alu_q <= '0;
      dm_q  <= '0;
      for (int i = 0; i < REG_NUM; i++) rf_q[i] <= '0;
    end else begin
      op_q  <= instr_M[31:26];
      fun_q <= instr_M[5:0];
      rt_q  <= instr_M[20:16];
      rd_q  <= instr_M[15:11];
      pc_q  <= pc_M;
      alu_q <= alu_M;
      dm_q  <= dm_M;
      if (we_W) rf_q[wa_W] <= wd_W;
    end
  assign op_W  = op_q;
  assign fun_W = fun_q;
  assign pc_W  = pc_q;
  assign by = 8'(dm_q >> {alu_q[1:0], 3'b000});
  assign hw = alu_q[1] ? dm_q[31:16] : dm_q[15:0];
  always_comb
    ld = op_q == 6'b100000 ? {{24{by[7]}}, by} :
         op_q == 6'b100100 ? {24'h0, by} :
         op_q == 6'b100001 ? {{16{hw[15]}}, hw} :
         op_q == 6'b100101 ? {16'h0, hw} : dm_q;
  assign wa    = WAop == 2'd0 ? rd_q : WAop == 2'd1 ? rt_q : WAop == 2'd2 ? 5'd31 : 5'd0;
  assign we_W  = GRFwe && wa != 5'd0;
  assign wa_W  = we_W ? wa : 5'd0;
  assign wd_W  = WDop == 2'd0 ? alu_q : WDop == 2'd1 ? ld : WDop == 2'd2 ? pc_q + 32'd8 : 32'h0;
  assign rd1_D = ra1_D == 5'd0 ? 32'h0 : (we_W && ra1_D == wa_W) ? wd_W : rf_q[ra1_D];
  assign rd2_D = ra2_D == 5'd0 ? 32'h0 : (we_W && ra2_D == wa_W) ? wd_W : rf_q[ra2_D];
endmodule

// File: tb/tb_w_stage_grf.sv
// tb_w_stage_grf: scoreboard bench for the write-back stage and register file
module tb_w_stage_grf;
  logic        clk = 0, reset_n = 0;
  logic [31:0] instr_M = 0, pc_M = 0, alu_M = 0, dm_M = 0;
  logic [5:0]  op_W, fun_W;
  logic        GRFwe = 0;
  logic [1:0]  WAop = 0, WDop = 0;
  logic [4:0]  ra1_D = 0, ra2_D = 0;
  logic [31:0] rd1_D, rd2_D, wd_W, pc_W;
  logic [4:0]  wa_W;
  logic        we_W;
  int cyc = 0, total = 0, passed = 0;
  typedef struct {int cyc; int id; logic [31:0] exp; string name;} chk_t;
  chk_t sbq[$];
  w_stage_grf dut (
    .clk(clk), .reset_n(reset_n), .instr_M(instr_M), .pc_M(pc_M), .alu_M(alu_M), .dm_M(dm_M),
    .op_W(op_W), .fun_W(fun_W), .GRFwe(GRFwe), .WAop(WAop), .WDop(WDop),
    .ra1_D(ra1_D), .ra2_D(ra2_D), .rd1_D(rd1_D), .rd2_D(rd2_D),
    .wa_W(wa_W), .wd_W(wd_W), .we_W(we_W), .pc_W(pc_W)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] val(int id);
    return id == 0 ? pc_W : id == 1 ? 32'(we_W) : id == 2 ? 32'(wa_W) : id == 3 ? wd_W :
           id == 4 ? rd1_D : id == 5 ? rd2_D : id == 6 ? 32'(op_W) : 32'(fun_W);
  endfunction
  always @(negedge clk)
    while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      chk_t c;
      c = sbq.pop_front();
      total++;
      if (c.cyc == cyc && val(c.id) === c.exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", c.name, val(c.id), c.exp, cyc);
    end
  task automatic chk(int id, logic [31:0] exp, string name);
    sbq.push_back('{cyc, id, exp, name});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic mi(logic [31:0] i, logic [31:0] p, logic [31:0] a, logic [31:0] d);
    instr_M = i; pc_M = p; alu_M = a; dm_M = d;
  endtask
  task automatic ctl(logic w, logic [1:0] a, logic [1:0] d);
    GRFwe = w; WAop = a; WDop = d;
  endtask
  logic [5:0]  ld_op  [6] = '{6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100001, 6'b100011};
  logic [31:0] ld_alu [6] = '{32'h2, 32'h3, 32'h0, 32'h2, 32'h3, 32'h0};
  logic [31:0] ld_exp [6] = '{32'hFFFFFFFF, 32'h00000080, 32'h00007F01, 32'h000080FF, 32'hFFFF80FF, 32'h80FF7F01};
  initial begin
    ctl(0, 0, 0);
    repeat (4) begin
      tick();
      mi($urandom, $urandom, $urandom, $urandom);
      ra1_D = 5'($urandom); ra2_D = 5'($urandom);
      chk(0, 32'h3000, "reset_pc"); chk(1, 0, "reset_we"); chk(2, 0, "reset_wa");
      chk(3, 0, "reset_wd"); chk(4, 0, "reset_rd1"); chk(5, 0, "reset_rd2");
      chk(6, 0, "reset_op"); chk(7, 0, "reset_fun");
    end
    reset_n = 1;
    mi(0, 32'h3000, 0, 0);
    tick();
    ctl(0, 0, 0); ra1_D = 5; ra2_D = 31;
    chk(1, 0, "bubble_we"); chk(4, 0, "bubble_rd1"); chk(5, 0, "bubble_rd2");
    mi(32'h0022_1821, 32'h3004, 32'h1234_5678, 0);
    tick();
    mi(0, 32'h3008, 0, 0);
    ctl(1, 0, 0); ra1_D = 3; ra2_D = 0;
    chk(6, 0, "addu_op"); chk(7, 32'h21, "addu_fun"); chk(0, 32'h3004, "addu_pc");
    chk(1, 1, "addu_we"); chk(2, 3, "addu_wa"); chk(3, 32'h12345678, "addu_wd");
    chk(4, 32'h12345678, "addu_bypass"); chk(5, 0, "addu_rd2_zero");
    tick();
    ctl(0, 0, 0);
    chk(4, 32'h12345678, "addu_array");
    for (int i = 0; i < 6; i++) begin
      mi({ld_op[i], 5'd1, 5'd4, 16'h0}, 32'h3100 + 32'(i * 4), ld_alu[i], 32'h80FF_7F01);
      tick();
      ctl(1, 1, 1); ra1_D = 4; ra2_D = 3;
      chk(2, 4, "load_wa"); chk(3, ld_exp[i], "load_wd"); chk(4, ld_exp[i], "load_bypass");
      chk(5, 32'h12345678, "load_rd2_other");
    end
    mi(0, 32'h3200, 0, 0);
    tick();
    ctl(0, 0, 0);
    chk(4, 32'h80FF7F01, "lw_array");
    mi({6'b000011, 26'h0}, 32'h3010, 0, 0);
    tick();
    mi(0, 32'h3014, 0, 0);
    ctl(1, 2, 2); ra1_D = 31;
    chk(2, 31, "jal_wa"); chk(3, 32'h3018, "jal_wd"); chk(0, 32'h3010, "jal_pc");
    tick();
    ctl(0, 0, 0);
    chk(4, 32'h3018, "jal_array");
    mi({6'b001101, 5'd1, 5'd0, 16'hFFFF}, 32'h3018, 32'h0000_FFFF, 0);
    tick();
    ctl(1, 1, 0); ra1_D = 0; ra2_D = 0;
    chk(1, 0, "r0_we"); chk(2, 0, "r0_wa"); chk(3, 32'hFFFF, "r0_wd"); chk(4, 0, "r0_rd1");
    mi(32'h0022_2821, 32'h301C, 32'hDEAD_BEEF, 0);
    tick();
    mi(0, 32'h3000, 0, 0);
    ctl(1, 0, 0); ra1_D = 5; ra2_D = 3;
    #1 reset_n = 0;
    chk(1, 0, "midrst_we"); chk(4, 0, "midrst_rd1"); chk(5, 0, "midrst_rd2"); chk(0, 32'h3000, "midrst_pc");
    tick();
    reset_n = 1;
    ctl(0, 0, 0);
    tick();
    ra2_D = 31;
    chk(4, 0, "postrst_r5"); chk(5, 0, "postrst_r31");
    tick();
    tick();
    if (sbq.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
